mem_port_arb: RTL and testbench

Two-requester arbiter that shares one cache-style memory port, with rd/wr/addr/data/byte-enable and a waitrequest handshake, between the mem stage (port 0) and a secondary master (port 1, e.g. a write-buffer drain or instruction refill). It sits between the requesters and the data cache. Port 0 has priority; a starvation counter bounds port 1's wait. Once a transaction is granted, it is locked to its owner until the cache completes it.

---
 rtl/mem_port_arb.sv | 135 +++++++++++++
 tb/tb_mem_port_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - two-port arbiter sharing one cache memory port, port 0 priority with starvation bound
module mem_port_arb #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BE_WIDTH     = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  p0_rd,
    input  logic                  p0_wr,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wr_data,
    input  logic [BE_WIDTH-1:0]   p0_wr_be,
    output logic [DATA_WIDTH-1:0] p0_data,
    output logic                  p0_waitrequest,

    input  logic                  p1_rd,
    input  logic                  p1_wr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wr_data,
    input  logic [BE_WIDTH-1:0]   p1_wr_be,
    output logic [DATA_WIDTH-1:0] p1_data,
    output logic                  p1_waitrequest,

    output logic                  cache_rd,
    output logic                  cache_wr,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [BE_WIDTH-1:0]   cache_wr_be,
    input  logic [DATA_WIDTH-1:0] cache_data,
    input  logic                  cache_waitrequest,

    output logic [1:0]            owner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("mem_port_arb: STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             req0;
    logic             req1;
    logic             grant0;
    logic             grant1;

    assign req0 = p0_rd | p0_wr;
    assign req1 = p1_rd | p1_wr;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Grant decision: same-cycle in IDLE, held by the owner while locked.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                grant1 = req1 & (~req0 | (starve_cnt == CNT_MAX));
                grant0 = req0 & ~grant1;
                if (grant0 && cache_waitrequest) begin
                    state_next = LOCK0;
                end else if (grant1 && cache_waitrequest) begin
                    state_next = LOCK1;
                end
            end
            LOCK0: begin
                grant0 = req0;
                if (!req0 || !cache_waitrequest) begin
                    state_next = IDLE;
                end
            end
            LOCK1: begin
                grant1 = req1;
                if (!req1 || !cache_waitrequest) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!reset_n) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    // Waiting cycles of port 1 count up; a completed port-1 transfer resets the bound.
    always_comb begin
        starve_next = starve_cnt;
        if (grant1 && !cache_waitrequest) begin
            starve_next = '0;
        end else if (req1 && !grant1 && (starve_cnt != CNT_MAX)) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // With no owner the address/data mux rests on port 0 and rd/wr are gated off.
    assign cache_rd      = (grant0 & p0_rd) | (grant1 & p1_rd);
    assign cache_wr      = (grant0 & p0_wr) | (grant1 & p1_wr);
    assign cache_addr    = grant1 ? p1_addr    : p0_addr;
    assign cache_wr_data = grant1 ? p1_wr_data : p0_wr_data;
    assign cache_wr_be   = grant1 ? p1_wr_be   : p0_wr_be;

    assign p0_data = cache_data;
    assign p1_data = cache_data;

    assign p0_waitrequest = !reset_n ? 1'b1 : (grant0 ? cache_waitrequest : req0);
    assign p1_waitrequest = !reset_n ? 1'b1 : (grant1 ? cache_waitrequest : req1);

    assign owner = {grant1, grant0};

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - scoreboard bench for mem_port_arb
module tb_mem_port_arb;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    logic        clock;
    logic        reset_n;
    logic        p0_rd, p0_wr, p1_rd, p1_wr;
    logic [31:0] p0_addr, p1_addr, p0_wr_data, p1_wr_data;
    logic [3:0]  p0_wr_be, p1_wr_be;
    logic [31:0] p0_data, p1_data;
    logic        p0_waitrequest, p1_waitrequest;
    logic        cache_rd, cache_wr;
    logic [31:0] cache_addr, cache_wr_data, cache_data;
    logic [3:0]  cache_wr_be;
    logic        cache_waitrequest;
    logic [1:0]  owner;

    typedef struct packed {
        logic        rstn;
        logic [1:0]  r0;
        logic [1:0]  r1;
        logic        cw;
    } stim_t;

    typedef struct packed {
        logic [1:0]  own;
        logic        crd;
        logic        cwr;
        logic [31:0] addr;
        logic        w0;
        logic        w1;
    } exp_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] d0;
        logic [31:0] d1;
    } dexp_t;

    stim_t stq[$];
    exp_t  sb[$];
    dexp_t dsb[$];
    exp_t  obs;
    dexp_t dobs;
    int    total;
    int    bad;

    assign obs  = {owner, cache_rd, cache_wr, cache_addr, p0_waitrequest, p1_waitrequest};
    assign dobs = {cache_wr_data, cache_wr_be, p0_data, p1_data};

    mem_port_arb #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
        .p0_wr_be(p0_wr_be), .p0_data(p0_data), .p0_waitrequest(p0_waitrequest),
        .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
        .p1_wr_be(p1_wr_be), .p1_data(p1_data), .p1_waitrequest(p1_waitrequest),
        .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_addr(cache_addr),
        .cache_wr_data(cache_wr_data), .cache_wr_be(cache_wr_be),
        .cache_data(cache_data), .cache_waitrequest(cache_waitrequest),
        .owner(owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // r0/r1 are {rd, wr}; one stimulus row and its expected outputs go in together.
    task automatic add(input logic rstn, input logic [1:0] r0, input logic [1:0] r1, input logic cw,
                       input logic [1:0] own, input logic crd, input logic cwr,
                       input logic [31:0] addr, input logic w0, input logic w1);
        stq.push_back('{rstn: rstn, r0: r0, r1: r1, cw: cw});
        sb.push_back('{own: own, crd: crd, cwr: cwr, addr: addr, w0: w0, w1: w1});
    endtask

    task automatic apply(input stim_t s);
        reset_n           = s.rstn;
        {p0_rd, p0_wr}    = s.r0;
        {p1_rd, p1_wr}    = s.r1;
        cache_waitrequest = s.cw;
    endtask

    task automatic test_reset();
        exp_t e;
        int n = 0;
        add(0, 2'b10, 2'b10, 0, 2'b00, 0, 0, A0, 1, 1);
        add(0, 2'b10, 2'b10, 0, 2'b00, 0, 0, A0, 1, 1);
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, A0, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_p0_only();
        exp_t e;
        int n = 0;
        add(1, 2'b10, 2'b00, 0, 2'b01, 1, 0, A0, 0, 0);
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, A0, 0, 0);
        add(1, 2'b00, 2'b10, 0, 2'b10, 1, 0, A1, 0, 0);
        add(1, 2'b11, 2'b00, 0, 2'b01, 1, 1, A0, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL p0_only cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_lock();
        exp_t e;
        int n = 0;
        add(1, 2'b01, 2'b00, 1, 2'b01, 0, 1, A0, 1, 0);
        add(1, 2'b01, 2'b10, 1, 2'b01, 0, 1, A0, 1, 1);
        add(1, 2'b01, 2'b10, 1, 2'b01, 0, 1, A0, 1, 1);
        add(1, 2'b01, 2'b10, 0, 2'b01, 0, 1, A0, 0, 1);
        add(1, 2'b00, 2'b10, 0, 2'b10, 1, 0, A1, 0, 0);
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, A0, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL lock cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_priority();
        exp_t e;
        int n = 0;
        add(1, 2'b10, 2'b10, 0, 2'b01, 1, 0, A0, 0, 1);
        add(1, 2'b00, 2'b10, 0, 2'b10, 1, 0, A1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL priority cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    // Two full starvation rounds: the second proves the counter cleared after port 1 completed.
    task automatic test_starvation();
        exp_t e;
        int n = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) add(1, 2'b10, 2'b10, 0, 2'b01, 1, 0, A0, 0, 1);
            add(1, 2'b10, 2'b10, 0, 2'b10, 1, 0, A1, 1, 0);
        end
        add(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, A0, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL starvation cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_owner_drop();
        exp_t e;
        int n = 0;
        add(1, 2'b00, 2'b10, 1, 2'b10, 1, 0, A1, 0, 1);
        add(1, 2'b10, 2'b10, 1, 2'b10, 1, 0, A1, 1, 1);
        add(1, 2'b10, 2'b00, 1, 2'b00, 0, 0, A0, 1, 0);
        add(1, 2'b10, 2'b00, 0, 2'b01, 1, 0, A0, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL owner_drop cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_midlock();
        exp_t e;
        int n = 0;
        add(1, 2'b01, 2'b00, 1, 2'b01, 0, 1, A0, 1, 0);
        add(0, 2'b01, 2'b00, 1, 2'b00, 0, 0, A0, 1, 1);
        add(0, 2'b01, 2'b00, 1, 2'b00, 0, 0, A0, 1, 1);
        add(1, 2'b00, 2'b10, 0, 2'b10, 1, 0, A1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_midlock cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n = 0;
        add(1, 2'b10, 2'b00, 0, 2'b01, 1, 0, A0, 0, 0);
        add(1, 2'b00, 2'b10, 0, 2'b10, 1, 0, A1, 0, 0);
        add(1, 2'b10, 2'b00, 0, 2'b01, 1, 0, A0, 0, 0);
        add(1, 2'b01, 2'b00, 1, 2'b01, 0, 1, A0, 1, 0);
        add(1, 2'b01, 2'b10, 0, 2'b01, 0, 1, A0, 0, 1);
        add(1, 2'b00, 2'b10, 0, 2'b10, 1, 0, A1, 0, 0);
        while (stq.size() > 0) begin
            apply(stq.pop_front());
            @(negedge clock);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%h expected=%h", n, obs, e);
            end
            n++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_data_path();
        dexp_t e;
        for (int i = 0; i < 4; i++) begin
            p0_wr_data        = $urandom;
            p1_wr_data        = $urandom;
            p0_wr_be          = 4'($urandom_range(0, 15));
            p1_wr_be          = 4'($urandom_range(0, 15));
            cache_data        = $urandom;
            cache_waitrequest = 1'b0;
            {p0_rd, p0_wr}    = (i % 2 == 0) ? 2'b01 : 2'b00;
            {p1_rd, p1_wr}    = (i % 2 == 0) ? 2'b00 : 2'b01;
            if (i % 2 == 0) dsb.push_back('{wdata: p0_wr_data, be: p0_wr_be, d0: cache_data, d1: cache_data});
            else            dsb.push_back('{wdata: p1_wr_data, be: p1_wr_be, d0: cache_data, d1: cache_data});
            @(negedge clock);
            e = dsb.pop_front();
            total++;
            if (dobs !== e) begin
                bad++;
                $display("FAIL data_path it=%0d got=%h expected=%h", i, dobs, e);
            end
            @(posedge clock); #1;
        end
        {p0_rd, p0_wr, p1_rd, p1_wr} = 4'b0000;
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        reset_n           = 1'b0;
        {p0_rd, p0_wr}    = 2'b00;
        {p1_rd, p1_wr}    = 2'b00;
        p0_addr           = A0;
        p1_addr           = A1;
        p0_wr_data        = 32'h1111_1111;
        p1_wr_data        = 32'h2222_2222;
        p0_wr_be          = 4'hF;
        p1_wr_be          = 4'h3;
        cache_data        = 32'hDEAD_BEEF;
        cache_waitrequest = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_p0_only();
        test_lock();
        test_priority();
        test_starvation();
        test_owner_drop();
        test_reset_midlock();
        test_back_to_back();
        test_data_path();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
